cpu_bus_decoder: RTL and testbench
==================================

# cpu_bus_decoder

Parametrised CPU-bus front end between the external CPU bus pins and the BRAM-backed target blocks (controller, normal, STM, modulator, ...). It decodes N memory selects and filters the asynchronous write strobe into one write pulse per CPU write. It also holds a bank of address-offset registers written through the controller select, and returns registered read data. It replaces the fixed four-select, two-offset bus interface with a generic module.

## Interface
Parameters:
- NUM_SEL, 4: number of mapped BRAM selects; select index i is valid when i < NUM_SEL.
- SEL_W, 2: BRAM_SELECT width. Require 2**SEL_W >= NUM_SEL.
- ADDR_W, 14: BRAM address width.
- DATA_W, 16: data width.
- CTL_SEL, 0: select index of the controller.
- NUM_OFS, 2: number of offset registers.
- OFS_W, 5: width of each offset register. Require OFS_W <= DATA_W.
- OFS_BASE, 14'h0010: controller address of offset register 0; register k is at OFS_BASE+k.
- ERR_CLR_ADDR, 14'h0020: controller address that clears ERR_CNT.

Ports:
- BUS_CLK  in  1  bus clock, single clock domain.
- RST_N  in  1  asynchronous active-low reset.
- EN  in  1  CPU chip enable (asynchronous to BUS_CLK).
- RD  in  1  CPU read strobe.
- WE  in  1  CPU write strobe (asynchronous).
- RDWR  in  1  CPU bus direction.
- BRAM_SELECT  in  SEL_W  target select.
- BRAM_ADDR  in  ADDR_W  target address.
- DATA_IN  in  DATA_W  write data from the pad.
- RD_DATA_IN  in  NUM_SEL*DATA_W  read data from each target; slice i belongs to select i.
- SEL_EN  out  NUM_SEL  combinational: bit i = EN & (BRAM_SELECT == i).
- WR_STB  out  NUM_SEL  registered one-cycle write pulse per select.
- WR_ADDR  out  ADDR_W  address latched with WR_STB.
- WR_DATA  out  DATA_W  data latched with WR_STB.
- OFS  out  NUM_OFS*OFS_W  offset registers; slice k = register k.
- DATA_OUT  out  DATA_W  registered read data, driven to the pad.
- DATA_OE  out  1  combinational: EN & RD & RDWR. Drives the top-level tristate.
- ERR_CNT  out  8  saturating count of writes to unmapped selects.

## Operation
- Reset values: WR_STB=0, WR_ADDR=0, WR_DATA=0, all OFS=0, DATA_OUT=0, ERR_CNT=0, write history=3'b000.
- Write filter:
  - On every BUS_CLK edge: hist <= {hist[1:0], WE & EN}.
  - A write commits on the edge where hist == 3'b011 before the update.
  - Result: exactly one commit per rising edge of WE&EN that is held for at least 2 samples.
  - A single-sample glitch (001 -> 010) commits nothing.
  - Holding WE high longer does not produce further commits.
- On commit, in the same edge:
  - WR_ADDR <= BRAM_ADDR and WR_DATA <= DATA_IN.
  - If BRAM_SELECT < NUM_SEL: WR_STB <= one-hot(BRAM_SELECT).
  - If BRAM_SELECT >= NUM_SEL: WR_STB <= 0 and ERR_CNT <= min(ERR_CNT+1, 255).
  - If BRAM_SELECT == CTL_SEL and BRAM_ADDR == OFS_BASE+k (k < NUM_OFS): OFS[k] <= DATA_IN[OFS_W-1:0] (truncated).
  - If BRAM_SELECT == CTL_SEL and BRAM_ADDR == ERR_CLR_ADDR: ERR_CNT <= 0.
  - Controller writes still pulse WR_STB[CTL_SEL], so the controller BRAM also stores the value.
- On all non-commit edges: WR_STB <= 0.
- Read, every edge:
  - If controller select and address is in the OFS range: DATA_OUT <= zero-extended OFS[k].
  - Else if select is mapped: DATA_OUT <= RD_DATA_IN slice for BRAM_SELECT.
  - Else: DATA_OUT <= 0.

## Timing
- Write latency: edge 0 is the first edge that samples WE&EN=1. History reads 011 after edge 1. At edge 2, WR_STB, WR_ADDR, WR_DATA, OFS and ERR_CNT update. WR_STB is high only from edge 2 to edge 3.
- The CPU must hold BRAM_SELECT, BRAM_ADDR and DATA_IN stable from WE rise until at least edge 2.
- Minimum WE low time between writes is 1 BUS_CLK sample, so history can return through x0x.
- Read latency: DATA_OUT reflects the address sampled at the previous edge (1 cycle). DATA_OE and SEL_EN are combinational, with zero latency.
- ERR_CNT saturates at 255. An unmapped write at 255 leaves it at 255.
- Reset mid-write clears history. If WE&EN is still high when RST_N releases, a new commit occurs 2 edges after release.

## Configuration
- CPU_BUS_ERR_CNT_EN:
  - Defined: ERR_CNT counter and ERR_CLR_ADDR clear logic are built as above.
  - Undefined: ERR_CNT is tied to 8'h00. Unmapped writes are still dropped (WR_STB=0), and ERR_CLR_ADDR is an ordinary controller address.

## Test plan
- Basic write: NUM_SEL=4; select 2, addr 14'h0123, data 16'hBEEF, WE held 5 cycles -> WR_STB=4'b0100 for exactly 1 cycle, 2 edges after first sample; WR_ADDR=14'h0123, WR_DATA=16'hBEEF.
- Glitch: WE&EN high for 1 sample only -> no WR_STB and no register change.
- Offset register: controller write of 16'hFFF3 to OFS_BASE+1 -> OFS[1]=5'h13 and WR_STB[0] pulses. A following read of OFS_BASE+1 -> DATA_OUT=16'h0013 one cycle after the address.
- Unmapped writes: NUM_SEL=3, 257 writes to select 3 -> ERR_CNT=255, WR_STB never asserted. A write to ERR_CLR_ADDR -> ERR_CNT=0. Macro undefined -> ERR_CNT stays 0 throughout.
- Read mux: RD_DATA_IN slice 1=16'h1234, select 1, RD=RDWR=EN=1 -> DATA_OE=1 immediately, DATA_OUT=16'h1234 after 1 edge.
- Reset: assert RST_N low between edge 0 and edge 1 of a write -> no commit, all outputs 0. With WE still high at release -> commit 2 edges later.

Source files
------------

// File: rtl/cpu_bus_decoder.sv
// cpu_bus_decoder: generic CPU-bus front end for the BRAM-backed targets.
// - Decodes NUM_SEL memory selects.
// - Filters the asynchronous write strobe into one commit per CPU write.
// - Holds NUM_OFS offset registers written through the controller select.
// - Returns registered read data.
// Optional feature macro: CPU_BUS_ERR_CNT_EN builds the unmapped-write
// error counter and its clear address; otherwise ERR_CNT reads 8'h00.
module cpu_bus_decoder #(
  parameter int                NUM_SEL      = 4,
  parameter int                SEL_W        = 2,
  parameter int                ADDR_W       = 14,
  parameter int                DATA_W       = 16,
  parameter int                CTL_SEL      = 0,
  parameter int                NUM_OFS      = 2,
  parameter int                OFS_W        = 5,
  parameter logic [ADDR_W-1:0] OFS_BASE     = 14'h0010,
  parameter logic [ADDR_W-1:0] ERR_CLR_ADDR = 14'h0020
) (
  input  logic                      BUS_CLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      RD,
  input  logic                      WE,
  input  logic                      RDWR,
  input  logic [SEL_W-1:0]          BRAM_SELECT,
  input  logic [ADDR_W-1:0]         BRAM_ADDR,
  input  logic [DATA_W-1:0]         DATA_IN,
  input  logic [NUM_SEL*DATA_W-1:0] RD_DATA_IN,
  output logic [NUM_SEL-1:0]        SEL_EN,
  output logic [NUM_SEL-1:0]        WR_STB,
  output logic [ADDR_W-1:0]         WR_ADDR,
  output logic [DATA_W-1:0]         WR_DATA,
  output logic [NUM_OFS*OFS_W-1:0]  OFS,
  output logic [DATA_W-1:0]         DATA_OUT,
  output logic                      DATA_OE,
  output logic [7:0]                ERR_CNT
);

  localparam logic [SEL_W:0]   NUM_SEL_C = (SEL_W+1)'(NUM_SEL);
  localparam logic [SEL_W-1:0] CTL_SEL_C = SEL_W'(CTL_SEL);

  logic [2:0]         hist_q, hist_d;
  logic               commit_s;
  logic               sel_mapped_s;
  logic               ctl_sel_s;
  logic [NUM_OFS-1:0] ofs_hit_s;

  logic [NUM_SEL-1:0] wr_stb_q, wr_stb_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [OFS_W-1:0]   ofs_q [NUM_OFS];
  logic [OFS_W-1:0]   ofs_d [NUM_OFS];
  logic [DATA_W-1:0]  data_out_d, data_out_q;

  // Address decode shared by the write and read paths.
  always_comb begin
    sel_mapped_s = ({1'b0, BRAM_SELECT} < NUM_SEL_C);
    ctl_sel_s    = (BRAM_SELECT == CTL_SEL_C);
    for (int k = 0; k < NUM_OFS; k++) begin
      ofs_hit_s[k] = ctl_sel_s && (BRAM_ADDR == (OFS_BASE + ADDR_W'(k)));
    end
  end

  // Combinational chip-select fan-out and pad output enable.
  always_comb begin
    for (int i = 0; i < NUM_SEL; i++) begin
      SEL_EN[i] = EN && (BRAM_SELECT == SEL_W'(i));
    end
    DATA_OE = EN & RD & RDWR;
  end

  // Write filter: commit once when the strobe has been seen for two samples.
  always_comb begin
    hist_d   = {hist_q[1:0], WE & EN};
    commit_s = (hist_q == 3'b011);
  end

  // Write path: strobe, latched address/data and offset register updates.
  always_comb begin
    wr_stb_d  = '0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    for (int k = 0; k < NUM_OFS; k++) begin
      ofs_d[k] = ofs_q[k];
    end
    if (commit_s) begin
      wr_addr_d = BRAM_ADDR;
      wr_data_d = DATA_IN;
      // Only mapped indices have a strobe bit, so unmapped selects drop here.
      for (int i = 0; i < NUM_SEL; i++) begin
        wr_stb_d[i] = (BRAM_SELECT == SEL_W'(i));
      end
      for (int k = 0; k < NUM_OFS; k++) begin
        if (ofs_hit_s[k]) begin
          ofs_d[k] = DATA_IN[OFS_W-1:0];
        end else begin
          ofs_d[k] = ofs_q[k];
        end
      end
    end else begin
      wr_stb_d = '0;
    end
  end

  // Read mux: offset registers shadow the controller BRAM at their addresses.
  always_comb begin
    data_out_d = '0;
    if (|ofs_hit_s) begin
      for (int k = 0; k < NUM_OFS; k++) begin
        if (ofs_hit_s[k]) begin
          data_out_d = DATA_W'(ofs_q[k]);
        end else begin
          data_out_d = data_out_d;
        end
      end
    end else if (sel_mapped_s) begin
      for (int i = 0; i < NUM_SEL; i++) begin
        if (BRAM_SELECT == SEL_W'(i)) begin
          data_out_d = RD_DATA_IN[i*DATA_W +: DATA_W];
        end else begin
          data_out_d = data_out_d;
        end
      end
    end else begin
      data_out_d = '0;
    end
  end

  // State registers for history, write outputs, offsets and read data.
  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      hist_q     <= 3'b000;
      wr_stb_q   <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      data_out_q <= '0;
      for (int k = 0; k < NUM_OFS; k++) begin
        ofs_q[k] <= '0;
      end
    end else begin
      hist_q     <= hist_d;
      wr_stb_q   <= wr_stb_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      data_out_q <= data_out_d;
      for (int k = 0; k < NUM_OFS; k++) begin
        ofs_q[k] <= ofs_d[k];
      end
    end
  end

  assign WR_STB   = wr_stb_q;
  assign WR_ADDR  = wr_addr_q;
  assign WR_DATA  = wr_data_q;
  assign DATA_OUT = data_out_q;

  for (genvar k = 0; k < NUM_OFS; k++) begin : g_ofs
    assign OFS[k*OFS_W +: OFS_W] = ofs_q[k];
  end

`ifdef CPU_BUS_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating unmapped-write counter with a controller-address clear.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (commit_s && ctl_sel_s && (BRAM_ADDR == ERR_CLR_ADDR)) begin
      err_cnt_d = 8'h00;
    end else if (commit_s && !sel_mapped_s && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge BUS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_cnt_q <= 8'h00;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign ERR_CNT = err_cnt_q;
`else
  assign ERR_CNT = 8'h00;
`endif

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Directed self-checking bench for cpu_bus_decoder (NUM_SEL=3 so select 3
// is unmapped). Inputs change and outputs are sampled on the falling edge.
module tb_cpu_bus_decoder;

  localparam int NUM_SEL = 3;
  localparam int SEL_W   = 2;
  localparam int ADDR_W  = 14;
  localparam int DATA_W  = 16;
  localparam int NUM_OFS = 2;
  localparam int OFS_W   = 5;

  logic                      BUS_CLK;
  logic                      RST_N;
  logic                      EN, RD, WE, RDWR;
  logic [SEL_W-1:0]          BRAM_SELECT;
  logic [ADDR_W-1:0]         BRAM_ADDR;
  logic [DATA_W-1:0]         DATA_IN;
  logic [NUM_SEL*DATA_W-1:0] RD_DATA_IN;
  logic [NUM_SEL-1:0]        SEL_EN;
  logic [NUM_SEL-1:0]        WR_STB;
  logic [ADDR_W-1:0]         WR_ADDR;
  logic [DATA_W-1:0]         WR_DATA;
  logic [NUM_OFS*OFS_W-1:0]  OFS;
  logic [DATA_W-1:0]         DATA_OUT;
  logic                      DATA_OE;
  logic [7:0]                ERR_CNT;

  int checks   = 0;
  int failures = 0;

  cpu_bus_decoder #(
    .NUM_SEL(NUM_SEL), .SEL_W(SEL_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .CTL_SEL(0), .NUM_OFS(NUM_OFS), .OFS_W(OFS_W),
    .OFS_BASE(14'h0010), .ERR_CLR_ADDR(14'h0020)
  ) dut (
    .BUS_CLK(BUS_CLK), .RST_N(RST_N), .EN(EN), .RD(RD), .WE(WE), .RDWR(RDWR),
    .BRAM_SELECT(BRAM_SELECT), .BRAM_ADDR(BRAM_ADDR), .DATA_IN(DATA_IN),
    .RD_DATA_IN(RD_DATA_IN), .SEL_EN(SEL_EN), .WR_STB(WR_STB),
    .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .OFS(OFS), .DATA_OUT(DATA_OUT),
    .DATA_OE(DATA_OE), .ERR_CNT(ERR_CNT)
  );

  initial BUS_CLK = 1'b0;
  always #5 BUS_CLK = ~BUS_CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CPU write: strobe for two samples, data stable through the commit
  // edge; returns just after the commit edge.
  task automatic do_write(input logic [SEL_W-1:0] sel, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] data);
    BRAM_SELECT = sel;
    BRAM_ADDR   = addr;
    DATA_IN     = data;
    EN          = 1'b1;
    WE          = 1'b1;
    @(negedge BUS_CLK);
    @(negedge BUS_CLK);
    WE = 1'b0;
    @(negedge BUS_CLK);
  endtask

  initial begin
    logic [NUM_SEL-1:0] exp_stb;
    logic               stb_seen;
    logic [7:0]         exp_err;

    RST_N = 1'b0; EN = 1'b0; RD = 1'b0; WE = 1'b0; RDWR = 1'b0;
    BRAM_SELECT = '0; BRAM_ADDR = '0; DATA_IN = '0;
    RD_DATA_IN = {16'hC0DE, 16'h1234, 16'hA5A5};
    repeat (2) @(negedge BUS_CLK);

    // Reset state
    check("rst_wr_stb",   WR_STB,   64'h0);
    check("rst_wr_addr",  WR_ADDR,  64'h0);
    check("rst_wr_data",  WR_DATA,  64'h0);
    check("rst_ofs",      OFS,      64'h0);
    check("rst_data_out", DATA_OUT, 64'h0);
    check("rst_err_cnt",  ERR_CNT,  64'h0);
    check("rst_sel_en",   SEL_EN,   64'h0);
    check("rst_data_oe",  DATA_OE,  64'h0);
    RST_N = 1'b1;
    @(negedge BUS_CLK);

    // Basic write, WE held 5 samples: pulse only after the third edge
    BRAM_SELECT = 2'd2; BRAM_ADDR = 14'h0123; DATA_IN = 16'hBEEF;
    EN = 1'b1; WE = 1'b1;
    #1 check("sel_en_sel2", SEL_EN, 64'h4);
    for (int c = 0; c < 5; c++) begin
      @(negedge BUS_CLK);
      exp_stb = (c == 2) ? 3'b100 : 3'b000;
      check($sformatf("basic_stb_c%0d", c), WR_STB, 64'(exp_stb));
    end
    check("basic_wr_addr", WR_ADDR, 64'h0123);
    check("basic_wr_data", WR_DATA, 64'hBEEF);
    WE = 1'b0;
    @(negedge BUS_CLK);
    check("basic_stb_after", WR_STB, 64'h0);

    // Single-sample glitch commits nothing
    BRAM_SELECT = 2'd1; BRAM_ADDR = 14'h0055; DATA_IN = 16'h1111; WE = 1'b1;
    @(negedge BUS_CLK);
    WE = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge BUS_CLK);
      check($sformatf("glitch_stb_c%0d", c), WR_STB, 64'h0);
    end
    check("glitch_wr_addr", WR_ADDR, 64'h0123);
    check("glitch_wr_data", WR_DATA, 64'hBEEF);

    // Offset registers via controller select (truncated to 5 bits)
    do_write(2'd0, 14'h0011, 16'hFFF3);
    check("ofs1_stb", WR_STB, 64'h1);
    check("ofs1_val", OFS,    64'h260);
    do_write(2'd0, 14'h0010, 16'h00AA);
    check("ofs0_stb", WR_STB, 64'h1);
    check("ofs0_val", OFS,    64'h26A);

    // Read mux
    EN = 1'b1; RD = 1'b1; RDWR = 1'b1;
    BRAM_SELECT = 2'd1; BRAM_ADDR = 14'h0055;
    #1 check("rd_data_oe", DATA_OE, 64'h1);
    check("rd_sel_en1", SEL_EN, 64'h2);
    @(negedge BUS_CLK);
    check("rd_slice1", DATA_OUT, 64'h1234);
    BRAM_SELECT = 2'd0; BRAM_ADDR = 14'h0011;
    #1 check("rd_ofs1_latency", DATA_OUT, 64'h1234);
    @(negedge BUS_CLK);
    check("rd_ofs1", DATA_OUT, 64'h0013);
    BRAM_ADDR = 14'h0010;
    @(negedge BUS_CLK);
    check("rd_ofs0", DATA_OUT, 64'h000A);
    BRAM_ADDR = 14'h0005;
    @(negedge BUS_CLK);
    check("rd_ctl_bram", DATA_OUT, 64'hA5A5);
    BRAM_SELECT = 2'd2;
    @(negedge BUS_CLK);
    check("rd_slice2", DATA_OUT, 64'hC0DE);
    BRAM_SELECT = 2'd3;
    @(negedge BUS_CLK);
    check("rd_unmapped", DATA_OUT, 64'h0);
    RDWR = 1'b0;
    #1 check("rd_oe_off", DATA_OE, 64'h0);
    RD = 1'b0;

    // Unmapped writes: dropped strobe, saturating error count
    stb_seen = 1'b0;
    do_write(2'd3, 14'h3FFF, 16'h5A5A);
`ifdef CPU_BUS_ERR_CNT_EN
    exp_err = 8'd1;
`else
    exp_err = 8'd0;
`endif
    check("err_cnt_1", ERR_CNT, 64'(exp_err));
    check("unmapped_wr_addr", WR_ADDR, 64'h3FFF);
    for (int n = 1; n < 257; n++) begin
      do_write(2'd3, 14'h3FFF, 16'h5A5A);
      stb_seen = stb_seen | (|WR_STB);
    end
`ifdef CPU_BUS_ERR_CNT_EN
    exp_err = 8'd255;
`else
    exp_err = 8'd0;
`endif
    check("unmapped_no_stb", 64'(stb_seen), 64'h0);
    check("err_cnt_sat", ERR_CNT, 64'(exp_err));
    do_write(2'd0, 14'h0020, 16'h0000);
    check("err_clr_stb", WR_STB,  64'h1);
    check("err_clr_cnt", ERR_CNT, 64'h0);
    check("err_clr_ofs", OFS,     64'h26A);

    // Reset between edge 0 and edge 1 of a write; WE stays high on release
    BRAM_SELECT = 2'd1; BRAM_ADDR = 14'h0077; DATA_IN = 16'h7777;
    EN = 1'b1; WE = 1'b1;
    @(negedge BUS_CLK);
    RST_N = 1'b0;
    #1;
    check("mid_rst_stb",  WR_STB,  64'h0);
    check("mid_rst_addr", WR_ADDR, 64'h0);
    check("mid_rst_data", WR_DATA, 64'h0);
    check("mid_rst_ofs",  OFS,     64'h0);
    @(negedge BUS_CLK);
    check("mid_rst_hold_stb", WR_STB, 64'h0);
    RST_N = 1'b1;
    @(negedge BUS_CLK);
    check("rel_stb_e0", WR_STB, 64'h0);
    @(negedge BUS_CLK);
    check("rel_stb_e1", WR_STB, 64'h0);
    @(negedge BUS_CLK);
    check("rel_stb_e2",  WR_STB,  64'h2);
    check("rel_wr_addr", WR_ADDR, 64'h0077);
    check("rel_wr_data", WR_DATA, 64'h7777);
    WE = 1'b0;
    @(negedge BUS_CLK);
    check("rel_stb_e3", WR_STB, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
